// File: rtl/book_levels.sv
// Multi-level limit order book: DEPTH sorted price levels per side, add/cancel
// ticks through a valid/ready handshake, one tick per IDLE->CMP->UPD pass.
module book_levels #(
  parameter  int DEPTH = 4,
  parameter  int PX_W  = 32,
  parameter  int QTY_W = 32,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_valid,
  output logic                   tick_ready,
  input  logic                   tick_type,
  input  logic                   tick_side,
  input  logic [QTY_W-1:0]       tick_qty,
  input  logic [PX_W-1:0]        tick_price,
  output logic [DEPTH*PX_W-1:0]  bid_px,
  output logic [DEPTH*QTY_W-1:0] bid_sz,
  output logic [DEPTH*PX_W-1:0]  ask_px,
  output logic [DEPTH*QTY_W-1:0] ask_sz,
  output logic [CW-1:0]          bid_cnt,
  output logic [CW-1:0]          ask_cnt,
  output logic                   upd_valid,
  output logic                   evict,
  output logic                   drop
);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_UPD} state_t;

  typedef struct packed {
    logic             typ;
    logic             side;
    logic [QTY_W-1:0] qty;
    logic [PX_W-1:0]  px;
  } tick_t;

  state_t r_state, w_nstate;
  tick_t  r_tk;
  logic   r_rdy, r_hit, r_upd, r_evict, r_drop;
  logic [CW-1:0] r_midx, r_iidx, r_bcnt, r_acnt;
  logic [DEPTH-1:0][PX_W-1:0]  r_bpx, r_apx;
  logic [DEPTH-1:0][QTY_W-1:0] r_bsz, r_asz;

  logic [DEPTH-1:0][PX_W-1:0]  w_cpx, w_npx;
  logic [DEPTH-1:0][QTY_W-1:0] w_csz, w_nsz;
  logic [CW-1:0]  w_ccnt, w_ncnt, w_hidx, w_iidx;
  logic [QTY_W-1:0] w_msz;
  logic [QTY_W:0]   w_sum;
  logic w_acc, w_hit, w_upd, w_evict, w_drop;

  assign w_acc  = tick_valid & r_rdy & (r_state == S_IDLE);
  assign w_cpx  = r_tk.side ? r_bpx  : r_apx;
  assign w_csz  = r_tk.side ? r_bsz  : r_asz;
  assign w_ccnt = r_tk.side ? r_bcnt : r_acnt;

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_nstate = S_CMP;
      S_CMP:   w_nstate = S_UPD;
      S_UPD:   w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Descending scan so the lowest matching/worse index wins.
  always_comb begin
    w_hit  = 1'b0;
    w_hidx = '0;
    w_iidx = w_ccnt;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (CW'(i) < w_ccnt) begin
        if (w_cpx[i] == r_tk.px) begin
          w_hit  = 1'b1;
          w_hidx = CW'(i);
        end
        if (r_tk.side ? (w_cpx[i] < r_tk.px) : (w_cpx[i] > r_tk.px))
          w_iidx = CW'(i);
      end
    end
  end

  always_comb begin
    w_npx   = w_cpx;
    w_nsz   = w_csz;
    w_ncnt  = w_ccnt;
    w_upd   = 1'b0;
    w_evict = 1'b0;
    w_drop  = 1'b0;
    w_msz   = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) == r_midx) w_msz = w_csz[i];
    w_sum = {1'b0, w_msz} + {1'b0, r_tk.qty};
    if (r_tk.qty != '0) begin
      if (!r_tk.typ) begin
        if (r_hit) begin
          w_upd = 1'b1;
          for (int i = 0; i < DEPTH; i++)
            if (CW'(i) == r_midx) w_nsz[i] = w_sum[QTY_W] ? '1 : w_sum[QTY_W-1:0];
        end else if (r_iidx < CW'(DEPTH)) begin
          w_upd   = 1'b1;
          w_evict = (w_ccnt == CW'(DEPTH));
          if (!w_evict) w_ncnt = w_ccnt + CW'(1);
          for (int i = 1; i < DEPTH; i++)
            if (CW'(i) > r_iidx) begin
              w_npx[i] = w_cpx[i-1];
              w_nsz[i] = w_csz[i-1];
            end
          for (int i = 0; i < DEPTH; i++)
            if (CW'(i) == r_iidx) begin
              w_npx[i] = r_tk.px;
              w_nsz[i] = r_tk.qty;
            end
        end else begin
          w_drop = 1'b1;
        end
      end else if (!r_hit) begin
        w_drop = 1'b1;
      end else if (r_tk.qty < w_msz) begin
        w_upd = 1'b1;
        for (int i = 0; i < DEPTH; i++)
          if (CW'(i) == r_midx) w_nsz[i] = w_msz - r_tk.qty;
      end else begin
        // Level fully consumed: close the gap and clear the tail.
        w_upd  = 1'b1;
        w_ncnt = w_ccnt - CW'(1);
        for (int i = 0; i < DEPTH-1; i++)
          if (CW'(i) >= r_midx) begin
            w_npx[i] = w_cpx[i+1];
            w_nsz[i] = w_csz[i+1];
          end
        w_npx[DEPTH-1] = '0;
        w_nsz[DEPTH-1] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b0;
      r_tk    <= '0;
      r_hit   <= 1'b0;
      r_midx  <= '0;
      r_iidx  <= '0;
      r_upd   <= 1'b0;
      r_evict <= 1'b0;
      r_drop  <= 1'b0;
      r_bpx   <= '0;
      r_bsz   <= '0;
      r_apx   <= '0;
      r_asz   <= '0;
      r_bcnt  <= '0;
      r_acnt  <= '0;
    end else begin
      r_state <= w_nstate;
      r_rdy   <= (w_nstate == S_IDLE);
      r_upd   <= 1'b0;
      r_evict <= 1'b0;
      r_drop  <= 1'b0;
      if (w_acc) r_tk <= '{typ: tick_type, side: tick_side, qty: tick_qty, px: tick_price};
      if (r_state == S_CMP) begin
        r_hit  <= w_hit;
        r_midx <= w_hidx;
        r_iidx <= w_iidx;
      end
      if (r_state == S_UPD) begin
        r_upd   <= w_upd;
        r_evict <= w_evict;
        r_drop  <= w_drop;
        if (w_upd) begin
          if (r_tk.side) begin
            r_bpx  <= w_npx;
            r_bsz  <= w_nsz;
            r_bcnt <= w_ncnt;
          end else begin
            r_apx  <= w_npx;
            r_asz  <= w_nsz;
            r_acnt <= w_ncnt;
          end
        end
      end
    end
  end

  assign tick_ready = r_rdy;
  assign bid_px     = r_bpx;
  assign bid_sz     = r_bsz;
  assign ask_px     = r_apx;
  assign ask_sz     = r_asz;
  assign bid_cnt    = r_bcnt;
  assign ask_cnt    = r_acnt;
  assign upd_valid  = r_upd;
  assign evict      = r_evict;
  assign drop       = r_drop;

endmodule

// File: tb/tb_book_levels.sv
// Directed bench for book_levels (DEPTH=4, 32-bit px/qty) with hand-computed books.
module tb_book_levels;

  logic         clk, rst_n;
  logic         tick_valid, tick_ready, tick_type, tick_side;
  logic [31:0]  tick_qty, tick_price;
  logic [127:0] bid_px, bid_sz, ask_px, ask_sz;
  logic [2:0]   bid_cnt, ask_cnt;
  logic         upd_valid, evict, drop;

  int n_vec = 0;
  int n_bad = 0;
  int n_upd = 0;

  book_levels dut (
    .clk(clk), .rst_n(rst_n),
    .tick_valid(tick_valid), .tick_ready(tick_ready),
    .tick_type(tick_type), .tick_side(tick_side),
    .tick_qty(tick_qty), .tick_price(tick_price),
    .bid_px(bid_px), .bid_sz(bid_sz), .ask_px(ask_px), .ask_sz(ask_sz),
    .bid_cnt(bid_cnt), .ask_cnt(ask_cnt),
    .upd_valid(upd_valid), .evict(evict), .drop(drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (upd_valid) n_upd++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Level 0 goes to the LSBs.
  function automatic logic [127:0] pk(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input string tag, input logic typ, input logic side,
                      input logic [31:0] qty, input logic [31:0] px,
                      input logic eu, input logic ee, input logic ed);
    logic rdy;
    bit   got;
    got = 0;
    tick_type = typ; tick_side = side; tick_qty = qty; tick_price = px;
    tick_valid = 1'b1;
    for (int j = 0; j < 10 && !got; j++) begin
      @(negedge clk); rdy = tick_ready;
      @(posedge clk); if (rdy) got = 1;
    end
    #1 tick_valid = 1'b0;
    if (!got) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    @(posedge clk); #1 chk({tag, "_lat1"}, {upd_valid, evict, drop}, 0);
    @(posedge clk); #1 chk({tag, "_strb"}, {upd_valid, evict, drop}, {eu, ee, ed});
  endtask

  initial begin
    clk = 0; rst_n = 0;
    tick_valid = 0; tick_type = 0; tick_side = 0; tick_qty = 0; tick_price = 0;

    repeat (10) @(posedge clk);
    #1;
    chk("rst_ready", tick_ready, 0);
    chk("rst_bpx", bid_px, 0);
    chk("rst_bsz", bid_sz, 0);
    chk("rst_apx", ask_px, 0);
    chk("rst_asz", ask_sz, 0);
    chk("rst_cnt", {bid_cnt, ask_cnt}, 0);
    chk("rst_strb", {upd_valid, evict, drop}, 0);
    @(negedge clk) rst_n = 1;
    #1 chk("rel_ready0", tick_ready, 0);
    @(posedge clk); #1 chk("rel_ready1", tick_ready, 1);

    // Reset while a tick sits in CMP: it must vanish.
    tick_type = 0; tick_side = 1; tick_qty = 1; tick_price = 500; tick_valid = 1;
    @(negedge clk); @(posedge clk); #1 tick_valid = 0;
    @(negedge clk) rst_n = 0;
    #1 chk("abort_ready", tick_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_bcnt", bid_cnt, 0);
    chk("abort_bpx", bid_px, 0);
    chk("abort_ready1", tick_ready, 1);

    // Sorted bid inserts.
    send("b10000", 0, 1, 10, 10000, 1, 0, 0);
    send("b10010", 0, 1, 5, 10010, 1, 0, 0);
    send("b10005", 0, 1, 20, 10005, 1, 0, 0);
    chk("ins_px", bid_px, pk(10010, 10005, 10000, 0));
    chk("ins_sz", bid_sz, pk(5, 20, 10, 0));
    chk("ins_cnt", bid_cnt, 3);

    send("b_agg", 0, 1, 7, 10005, 1, 0, 0);
    chk("agg_sz", bid_sz, pk(5, 27, 10, 0));

    // Saturating aggregate on the ask side.
    send("a_big", 0, 0, 32'hFFFFFFF0, 10020, 1, 0, 0);
    send("a_sat", 0, 0, 32'h20, 10020, 1, 0, 0);
    chk("sat_sz", ask_sz, pk(32'hFFFFFFFF, 0, 0, 0));
    chk("sat_cnt", ask_cnt, 1);

    // Fill the ask side, then insert with eviction, then drop.
    send("a10010", 0, 0, 1, 10010, 1, 0, 0);
    send("a10030", 0, 0, 1, 10030, 1, 0, 0);
    send("a10040", 0, 0, 1, 10040, 1, 0, 0);
    chk("full_px", ask_px, pk(10010, 10020, 10030, 10040));
    chk("full_cnt", ask_cnt, 4);
    send("a_evict", 0, 0, 1, 10015, 1, 1, 0);
    chk("ev_px", ask_px, pk(10010, 10015, 10020, 10030));
    chk("ev_sz", ask_sz, pk(1, 1, 32'hFFFFFFFF, 1));
    chk("ev_cnt", ask_cnt, 4);
    send("a_drop", 0, 0, 1, 10050, 0, 0, 1);
    chk("drop_px", ask_px, pk(10010, 10015, 10020, 10030));
    chk("drop_sz", ask_sz, pk(1, 1, 32'hFFFFFFFF, 1));
    chk("side_indep", bid_px, pk(10010, 10005, 10000, 0));

    // Cancels.
    send("c_part", 1, 1, 5, 10005, 1, 0, 0);
    chk("cpart_sz", bid_sz, pk(5, 22, 10, 0));
    send("c_rm", 1, 1, 9, 10010, 1, 0, 0);
    chk("crm_px", bid_px, pk(10005, 10000, 0, 0));
    chk("crm_sz", bid_sz, pk(22, 10, 0, 0));
    chk("crm_cnt", bid_cnt, 2);
    send("c_miss", 1, 1, 1, 9999, 0, 0, 1);
    chk("cmiss_px", bid_px, pk(10005, 10000, 0, 0));

    // Zero quantity: nothing at all happens.
    send("q0_add", 0, 1, 0, 10000, 0, 0, 0);
    send("q0_can", 1, 1, 0, 10005, 0, 0, 0);
    chk("q0_sz", bid_sz, pk(22, 10, 0, 0));

    send("c_exact", 1, 1, 10, 10000, 1, 0, 0);
    chk("cex_px", bid_px, pk(10005, 0, 0, 0));
    chk("cex_cnt", bid_cnt, 1);

    // Back-pressure: valid held high, three ticks back-to-back.
    @(posedge clk); #1 n_upd = 0;
    begin
      logic [31:0] bq [3] = '{3, 4, 22};
      logic [31:0] bp [3] = '{9990, 9980, 10005};
      logic        bt [3] = '{0, 0, 1};
      tick_valid = 1;
      for (int k = 0; k < 3; k++) begin
        logic rdy;
        bit   got;
        int   waits;
        got = 0; waits = 0;
        tick_type = bt[k]; tick_side = 1; tick_qty = bq[k]; tick_price = bp[k];
        for (int j = 0; j < 10 && !got; j++) begin
          @(negedge clk); rdy = tick_ready;
          if (k > 0 && j < 2) chk("bp_rdy_low", rdy, 0);
          @(posedge clk); waits++;
          if (rdy) got = 1;
        end
        if (!got) chk("bp_timeout", 0, 1);
        else if (k > 0) chk("bp_spacing", waits, 3);
        #1;
      end
      tick_valid = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("bp_nupd", n_upd, 3);
    chk("bp_px", bid_px, pk(9990, 9980, 0, 0));
    chk("bp_sz", bid_sz, pk(3, 4, 0, 0));
    chk("bp_cnt", bid_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
